// File: rtl/sub_serial_ctrl.sv
// rtl/sub_serial_ctrl.sv - nibble-serial subtractor time-sharing one 4-bit ripple-borrow slice
module sub4_ripple (
    input  logic       b_in,
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic [3:0] D,
    output logic       b4
);
    always_comb begin
        logic bw;
        bw = b_in;
        D  = '0;
        for (int i = 0; i < 4; i++) begin
            D[i] = A[i] ^ B[i] ^ bw;
            bw   = (~A[i] & B[i]) | (~(A[i] ^ B[i]) & bw);
        end
        b4 = bw;
    end
endmodule

module sub_serial_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    input  logic                 b_in,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] diff,
    output logic                 b_out,
    output logic                 zero
);
    localparam int W  = 4 * NIBBLES;
    localparam int CW = $clog2(NIBBLES);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic          borrow_q;
    logic [CW-1:0] cnt;
    logic [3:0]    a_nib;
    logic [3:0]    b_nib;
    logic [3:0]    d_nib;
    logic          b4;
    logic [W-1:0]  diff_next;
    logic          last;

    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (cnt == CW'(i)) begin
                a_nib = a_q[4*i +: 4];
                b_nib = b_q[4*i +: 4];
            end
        end
    end

    sub4_ripple u_slice (
        .b_in (borrow_q),
        .A    (a_nib),
        .B    (b_nib),
        .D    (d_nib),
        .b4   (b4)
    );

    // Completed diff including the nibble being written this cycle, so zero can be registered with it
    always_comb begin
        diff_next = diff;
        for (int i = 0; i < NIBBLES; i++) begin
            if (cnt == CW'(i)) begin
                diff_next[4*i +: 4] = d_nib;
            end
        end
    end

    assign last = (cnt == CW'(NIBBLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            borrow_q <= 1'b0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            diff     <= '0;
            b_out    <= 1'b0;
            zero     <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q      <= a;
                        b_q      <= b;
                        borrow_q <= b_in;
                        cnt      <= '0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    diff     <= diff_next;
                    borrow_q <= b4;
                    cnt      <= cnt + CW'(1);
                    if (last) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        b_out <= b4;
                        zero  <= (diff_next == '0);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sub_serial_ctrl.sv
// tb/tb_sub_serial_ctrl.sv - scoreboard bench for sub_serial_ctrl at NIBBLES = 2, 4, 8
module tb_sub_serial_ctrl;
    typedef struct {
        int          lane;
        logic [31:0] diff;
        logic        bout;
        logic        zero;
    } exp_t;

    localparam logic [15:0] V_A [5] = '{16'h1234, 16'h0000, 16'h8000, 16'hFFFF, 16'h0000};
    localparam logic [15:0] V_B [5] = '{16'h0235, 16'h0001, 16'h7FFF, 16'hFFFF, 16'h0000};
    localparam logic        V_I [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    localparam logic [15:0] V_D [5] = '{16'h0FFF, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000};
    localparam logic        V_O [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    localparam logic        V_Z [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  r_start;
    logic [2:0]  r_bin;
    logic [2:0]  r_busy;
    logic [2:0]  r_done;
    logic [2:0]  r_bout;
    logic [2:0]  r_zero;
    logic [31:0] r_a [3];
    logic [31:0] r_b [3];
    logic [31:0] r_diff [3];

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : lane
        localparam int NB = 2 << g;
        logic [4*NB-1:0] dd;
        sub_serial_ctrl #(.NIBBLES(NB)) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .start (r_start[g]),
            .a     (r_a[g][4*NB-1:0]),
            .b     (r_b[g][4*NB-1:0]),
            .b_in  (r_bin[g]),
            .busy  (r_busy[g]),
            .done  (r_done[g]),
            .diff  (dd),
            .b_out (r_bout[g]),
            .zero  (r_zero[g])
        );
        assign r_diff[g] = 32'(dd);
    end

    function automatic exp_t model(input int ln, input int nib, input logic [31:0] av,
                                   input logic [31:0] bv, input logic bi);
        exp_t e;
        longint unsigned m, x, y, c;
        m = (64'd1 << (4 * nib)) - 64'd1;
        x = {32'd0, av} & m;
        y = {32'd0, bv} & m;
        c = {63'd0, bi};
        e.lane = ln;
        e.diff = 32'((x - y - c) & m);
        e.bout = (x < y + c);
        e.zero = (e.diff == 32'd0);
        return e;
    endfunction

    task automatic sb_pop(input int ln, output exp_t e, output bit ok);
        int idx = -1;
        e  = '{lane: ln, diff: 32'd0, bout: 1'b0, zero: 1'b0};
        ok = 1'b0;
        for (int i = 0; i < sb.size(); i++)
            if (idx < 0 && sb[i].lane == ln) idx = i;
        if (idx >= 0) begin
            e  = sb[idx];
            ok = 1'b1;
            sb.delete(idx);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (r_busy[1] !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", r_busy[1]); end
        checks++; if (r_done[1] !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", r_done[1]); end
        checks++; if (r_diff[1] !== 32'd0) begin errors++; $display("FAIL reset_diff got %h want 0", r_diff[1]); end
        checks++; if (r_bout[1] !== 1'b0) begin errors++; $display("FAIL reset_bout got %b want 0", r_bout[1]); end
        checks++; if (r_zero[1] !== 1'b1) begin errors++; $display("FAIL reset_zero got %b want 1", r_zero[1]); end
        rst_n = 1'b1;
    endtask

    task automatic test_vectors();
        for (int i = 0; i < 5; i++) begin
            exp_t e;
            bit   ok;
            @(negedge clk);
            r_a[1] = {16'd0, V_A[i]}; r_b[1] = {16'd0, V_B[i]}; r_bin[1] = V_I[i]; r_start[1] = 1'b1;
            sb.push_back('{lane: 1, diff: {16'd0, V_D[i]}, bout: V_O[i], zero: V_Z[i]});
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                r_start[1] = 1'b0;
                checks++;
                if (r_busy[1] !== 1'b1 || r_done[1] !== 1'b0) begin
                    errors++; $display("FAIL vec%0d_run%0d busy=%b done=%b want busy=1 done=0", i, k, r_busy[1], r_done[1]);
                end
            end
            @(negedge clk);
            checks++;
            if (r_done[1] !== 1'b1 || r_busy[1] !== 1'b0) begin
                errors++; $display("FAIL vec%0d_done busy=%b done=%b want busy=0 done=1", i, r_busy[1], r_done[1]);
            end
            sb_pop(1, e, ok);
            checks++;
            if (!ok || r_diff[1] !== e.diff || r_bout[1] !== e.bout || r_zero[1] !== e.zero) begin
                errors++; $display("FAIL vec%0d_result diff=%h b_out=%b zero=%b want diff=%h b_out=%b zero=%b",
                                   i, r_diff[1], r_bout[1], r_zero[1], e.diff, e.bout, e.zero);
            end
            @(negedge clk);
            checks++;
            if (r_done[1] !== 1'b0 || r_diff[1] !== e.diff || r_bout[1] !== e.bout || r_zero[1] !== e.zero) begin
                errors++; $display("FAIL vec%0d_hold done=%b diff=%h b_out=%b zero=%b want done=0 diff=%h b_out=%b zero=%b",
                                   i, r_done[1], r_diff[1], r_bout[1], r_zero[1], e.diff, e.bout, e.zero);
            end
        end
    endtask

    task automatic test_ignore_start();
        exp_t e;
        bit   ok;
        int   dones = 0;
        int   busy_cycles = 0;
        @(negedge clk);
        r_a[1] = 32'h5555; r_b[1] = 32'h1111; r_bin[1] = 1'b0; r_start[1] = 1'b1;
        sb.push_back('{lane: 1, diff: 32'h4444, bout: 1'b0, zero: 1'b0});
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            r_a[1] = $urandom; r_b[1] = $urandom; r_bin[1] = 1'($urandom);
            r_start[1] = (k < 4) ? 1'(k % 2 == 0) : 1'b0;
            if (r_busy[1] === 1'b1) busy_cycles++;
            if (r_done[1] === 1'b1) begin
                dones++;
                sb_pop(1, e, ok);
                checks++;
                if (!ok || r_diff[1] !== e.diff || r_bout[1] !== e.bout || r_zero[1] !== e.zero) begin
                    errors++; $display("FAIL ignore_result diff=%h b_out=%b zero=%b want diff=%h b_out=%b zero=%b",
                                       r_diff[1], r_bout[1], r_zero[1], e.diff, e.bout, e.zero);
                end
            end
        end
        checks++; if (dones !== 1) begin errors++; $display("FAIL ignore_dones got %0d want 1", dones); end
        checks++; if (busy_cycles !== 4) begin errors++; $display("FAIL ignore_busy_cycles got %0d want 4", busy_cycles); end
    endtask

    task automatic test_reset_abort();
        exp_t e;
        bit   ok;
        bit   seen = 1'b0;
        @(negedge clk);
        r_a[1] = 32'h5A5A; r_b[1] = 32'h1234; r_bin[1] = 1'b1; r_start[1] = 1'b1;
        @(negedge clk);
        r_start[1] = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (r_busy[1] !== 1'b0 || r_done[1] !== 1'b0 || r_diff[1] !== 32'd0 || r_bout[1] !== 1'b0 || r_zero[1] !== 1'b1) begin
            errors++; $display("FAIL abort_async busy=%b done=%b diff=%h b_out=%b zero=%b want 0 0 0 0 1",
                               r_busy[1], r_done[1], r_diff[1], r_bout[1], r_zero[1]);
        end
        repeat (6) begin
            @(negedge clk);
            if (r_done[1] !== 1'b0 || r_busy[1] !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen) begin errors++; $display("FAIL abort_no_done saw busy/done during reset, want none"); end
        r_a[1] = 32'h0010; r_b[1] = 32'h0001; r_bin[1] = 1'b0; r_start[1] = 1'b1;
        sb.push_back('{lane: 1, diff: 32'h000F, bout: 1'b0, zero: 1'b0});
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        r_start[1] = 1'b0;
        checks++; if (r_busy[1] !== 1'b1) begin errors++; $display("FAIL abort_release_accept busy=%b want 1", r_busy[1]); end
        repeat (4) @(negedge clk);
        checks++; if (r_done[1] !== 1'b1) begin errors++; $display("FAIL abort_new_done done=%b want 1", r_done[1]); end
        sb_pop(1, e, ok);
        checks++;
        if (!ok || r_diff[1] !== e.diff || r_bout[1] !== e.bout || r_zero[1] !== e.zero) begin
            errors++; $display("FAIL abort_new_result diff=%h b_out=%b zero=%b want diff=%h b_out=%b zero=%b",
                               r_diff[1], r_bout[1], r_zero[1], e.diff, e.bout, e.zero);
        end
        @(negedge clk);
    endtask

    task automatic test_random(input int ln, input int nib, input int ops);
        exp_t e;
        bit   ok;
        bit   got;
        int   waited;
        int   last_cyc = 0;
        @(negedge clk);
        r_a[ln] = $urandom; r_b[ln] = $urandom; r_bin[ln] = 1'($urandom); r_start[ln] = 1'b1;
        sb.push_back(model(ln, nib, r_a[ln], r_b[ln], r_bin[ln]));
        for (int op = 0; op < ops; op++) begin
            got = 1'b0;
            waited = 0;
            while (!got && waited < 4 * nib + 8) begin
                @(negedge clk);
                waited++;
                got = (r_done[ln] === 1'b1);
            end
            checks++;
            if (!got) begin
                errors++; $display("FAIL rand_n%0d_timeout op %0d no done within %0d cycles", nib, op, waited);
                break;
            end
            sb_pop(ln, e, ok);
            checks++;
            if (!ok || r_busy[ln] !== 1'b0 || r_diff[ln] !== e.diff || r_bout[ln] !== e.bout || r_zero[ln] !== e.zero) begin
                errors++; $display("FAIL rand_n%0d_op%0d busy=%b diff=%h b_out=%b zero=%b want busy=0 diff=%h b_out=%b zero=%b",
                                   nib, op, r_busy[ln], r_diff[ln], r_bout[ln], r_zero[ln], e.diff, e.bout, e.zero);
            end
            if (op > 0) begin
                checks++;
                if (cyc - last_cyc !== nib + 2) begin
                    errors++; $display("FAIL rand_n%0d_spacing op %0d got %0d cycles want %0d", nib, op, cyc - last_cyc, nib + 2);
                end
            end
            last_cyc = cyc;
            if (op < ops - 1) begin
                r_a[ln] = $urandom; r_b[ln] = $urandom; r_bin[ln] = 1'($urandom);
                sb.push_back(model(ln, nib, r_a[ln], r_b[ln], r_bin[ln]));
            end else begin
                r_start[ln] = 1'b0;
            end
        end
    endtask

    initial begin
        r_start = '0;
        r_bin   = '0;
        for (int i = 0; i < 3; i++) begin
            r_a[i] = 32'd0;
            r_b[i] = 32'd0;
        end
        test_reset();
        test_vectors();
        test_ignore_start();
        test_reset_abort();
        fork
            test_random(0, 2, 1500);
            test_random(1, 4, 1500);
            test_random(2, 8, 1500);
        join
        checks++;
        if (sb.size() !== 0) begin errors++; $display("FAIL scoreboard_leftover got %0d entries want 0", sb.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1);
    end
endmodule
